// File: rtl/cellram_sched_pkg.sv
// rtl/cellram_sched_pkg.sv - shared state encoding and owner codes for the cellram Wishbone scheduler
package cellram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [1:0] MST_NONE = 2'b00;
  localparam logic [1:0] MST_M0   = 2'b01;
  localparam logic [1:0] MST_M1   = 2'b10;

  // Owner code shown on mst_sel_o for a given scheduler state
  function automatic logic [1:0] owner_of(input state_t st);
    case (st)
      GNT_M0:  owner_of = MST_M0;
      GNT_M1:  owner_of = MST_M1;
      default: owner_of = MST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - slave ack watchdog: counts strobed cycles without ack, flags timeout
module sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  input  logic clear,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt;

  // An ack in the same cycle as the last count suppresses the timeout
  assign timeout = active && !ack && (to_cnt == LAST);

  // Count strobed cycles still waiting for ack; restart on ack or owner change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (clear || ack) begin
      to_cnt <= '0;
    end else if (active && !timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cellram_wb_sched.sv
// rtl/cellram_wb_sched.sv - two-master Wishbone scheduler for cellram with m1 fairness and ack watchdog (optional stats: CELLRAM_SCHED_STATS_EN)
module cellram_wb_sched
  import cellram_sched_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int M0_MAX_GRANTS  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [AW-1:0]   wb_m0_adr_i,
  input  logic [DW-1:0]   wb_m0_dat_i,
  input  logic [DW/8-1:0] wb_m0_sel_i,
  input  logic            wb_m0_cyc_i,
  input  logic            wb_m0_stb_i,
  input  logic            wb_m0_we_i,
  output logic [DW-1:0]   wb_m0_dat_o,
  output logic            wb_m0_ack_o,
  output logic            wb_m0_err_o,
  input  logic [AW-1:0]   wb_m1_adr_i,
  input  logic [DW-1:0]   wb_m1_dat_i,
  input  logic [DW/8-1:0] wb_m1_sel_i,
  input  logic            wb_m1_cyc_i,
  input  logic            wb_m1_stb_i,
  input  logic            wb_m1_we_i,
  output logic [DW-1:0]   wb_m1_dat_o,
  output logic            wb_m1_ack_o,
  output logic            wb_m1_err_o,
  output logic [AW-1:0]   wb_s0_adr_o,
  output logic [DW-1:0]   wb_s0_dat_o,
  output logic [DW/8-1:0] wb_s0_sel_o,
  output logic            wb_s0_we_o,
  output logic            wb_s0_cyc_o,
  output logic            wb_s0_stb_o,
  input  logic [DW-1:0]   wb_s0_dat_i,
  input  logic            wb_s0_ack_i,
`ifdef CELLRAM_SCHED_STATS_EN
  output logic [15:0]     stat_m0_grants_o,
  output logic [15:0]     stat_m1_grants_o,
  output logic [7:0]      stat_timeouts_o,
`endif
  output logic [1:0]      mst_sel_o
);

  localparam int SW = $clog2(M0_MAX_GRANTS + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(M0_MAX_GRANTS);

  state_t        state, state_next;
  logic          drain_m1;
  logic [SW-1:0] starve_cnt;
  logic          timeout;
  logic          state_chg;
  logic          enter_m0, enter_m1;

  assign state_chg = (state_next != state);
  assign enter_m0  = (state == IDLE) && (state_next == GNT_M0);
  assign enter_m1  = (state == IDLE) && (state_next == GNT_M1);

  // Next-state: arbitrate in IDLE, hold grant while cyc is high, drain after a timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wb_m0_cyc_i && wb_m1_cyc_i) begin
          state_next = (starve_cnt == STARVE_MAX) ? GNT_M1 : GNT_M0;
        end else if (wb_m0_cyc_i) begin
          state_next = GNT_M0;
        end else if (wb_m1_cyc_i) begin
          state_next = GNT_M1;
        end
      end
      GNT_M0: begin
        if (timeout)           state_next = DRAIN;
        else if (!wb_m0_cyc_i) state_next = IDLE;
      end
      GNT_M1: begin
        if (timeout)           state_next = DRAIN;
        else if (!wb_m1_cyc_i) state_next = IDLE;
      end
      DRAIN: begin
        if (drain_m1 ? !wb_m1_cyc_i : !wb_m0_cyc_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, owner code and faulting-master memory
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      mst_sel_o <= MST_NONE;
      drain_m1  <= 1'b0;
    end else begin
      state     <= state_next;
      mst_sel_o <= owner_of(state_next);
      if (timeout) drain_m1 <= (state == GNT_M1);
    end
  end

  // Fairness: count m0 grants taken while m1 waits, saturating at the limit
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (enter_m1 || !wb_m1_cyc_i) begin
        starve_cnt <= '0;
      end else if (enter_m0 && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Bus steering: only the owner reaches the slave and sees ack/data
  always_comb begin
    wb_s0_adr_o = '0;
    wb_s0_dat_o = '0;
    wb_s0_sel_o = '0;
    wb_s0_we_o  = 1'b0;
    wb_s0_cyc_o = 1'b0;
    wb_s0_stb_o = 1'b0;
    wb_m0_dat_o = '0;
    wb_m0_ack_o = 1'b0;
    wb_m1_dat_o = '0;
    wb_m1_ack_o = 1'b0;
    case (state)
      GNT_M0: begin
        wb_s0_adr_o = wb_m0_adr_i;
        wb_s0_dat_o = wb_m0_dat_i;
        wb_s0_sel_o = wb_m0_sel_i;
        wb_s0_we_o  = wb_m0_we_i;
        wb_s0_cyc_o = wb_m0_cyc_i;
        wb_s0_stb_o = wb_m0_stb_i;
        wb_m0_dat_o = wb_s0_dat_i;
        wb_m0_ack_o = wb_s0_ack_i;
      end
      GNT_M1: begin
        wb_s0_adr_o = wb_m1_adr_i;
        wb_s0_dat_o = wb_m1_dat_i;
        wb_s0_sel_o = wb_m1_sel_i;
        wb_s0_we_o  = wb_m1_we_i;
        wb_s0_cyc_o = wb_m1_cyc_i;
        wb_s0_stb_o = wb_m1_stb_i;
        wb_m1_dat_o = wb_s0_dat_i;
        wb_m1_ack_o = wb_s0_ack_i;
      end
      default: ;
    endcase
  end

  assign wb_m0_err_o = timeout && (state == GNT_M0);
  assign wb_m1_err_o = timeout && (state == GNT_M1);

  sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .active  (wb_s0_stb_o),
    .ack     (wb_s0_ack_i),
    .clear   (state_chg),
    .timeout (timeout)
  );

`ifdef CELLRAM_SCHED_STATS_EN
  // Wrapping grant and timeout statistics
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      stat_m0_grants_o <= '0;
      stat_m1_grants_o <= '0;
      stat_timeouts_o  <= '0;
    end else begin
      if (enter_m0) stat_m0_grants_o <= stat_m0_grants_o + 16'd1;
      if (enter_m1) stat_m1_grants_o <= stat_m1_grants_o + 16'd1;
      if (timeout)  stat_timeouts_o  <= stat_timeouts_o + 8'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_cellram_wb_sched.sv
// tb/tb_cellram_wb_sched.sv - directed self-checking bench for cellram_wb_sched
module tb_cellram_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr, m0_dat, m0_rdat, m1_adr, m1_dat, m1_rdat;
  logic [3:0]  m0_sel, m1_sel, s0_sel;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [31:0] s0_adr, s0_wdat, s0_rdat;
  logic        s0_we, s0_cyc, s0_stb, s0_ack;
  logic [1:0]  mst_sel;
`ifdef CELLRAM_SCHED_STATS_EN
  logic [15:0] st_m0, st_m1;
  logic [7:0]  st_to;
`endif

  always #5 clk = ~clk;

  cellram_wb_sched dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wb_m0_adr_i (m0_adr),
    .wb_m0_dat_i (m0_dat),
    .wb_m0_sel_i (m0_sel),
    .wb_m0_cyc_i (m0_cyc),
    .wb_m0_stb_i (m0_stb),
    .wb_m0_we_i  (m0_we),
    .wb_m0_dat_o (m0_rdat),
    .wb_m0_ack_o (m0_ack),
    .wb_m0_err_o (m0_err),
    .wb_m1_adr_i (m1_adr),
    .wb_m1_dat_i (m1_dat),
    .wb_m1_sel_i (m1_sel),
    .wb_m1_cyc_i (m1_cyc),
    .wb_m1_stb_i (m1_stb),
    .wb_m1_we_i  (m1_we),
    .wb_m1_dat_o (m1_rdat),
    .wb_m1_ack_o (m1_ack),
    .wb_m1_err_o (m1_err),
    .wb_s0_adr_o (s0_adr),
    .wb_s0_dat_o (s0_wdat),
    .wb_s0_sel_o (s0_sel),
    .wb_s0_we_o  (s0_we),
    .wb_s0_cyc_o (s0_cyc),
    .wb_s0_stb_o (s0_stb),
    .wb_s0_dat_i (s0_rdat),
    .wb_s0_ack_i (s0_ack),
`ifdef CELLRAM_SCHED_STATS_EN
    .stat_m0_grants_o (st_m0),
    .stat_m1_grants_o (st_m1),
    .stat_timeouts_o  (st_to),
`endif
    .mst_sel_o   (mst_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int          grants[$];
  int          exp_g[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
  logic [1:0]  prev_sel;
  bit          acked;
  int          run, max_run, early;

  initial begin
    rst_n = 1'b0;
    m0_adr = '0; m0_dat = '0; m0_sel = 4'hF; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_adr = '0; m1_dat = '0; m1_sel = 4'hF; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s0_rdat = '0; s0_ack = 0;

    // reset state
    repeat (3) step();
    smp();
    chk("rst_mst_sel", mst_sel, 2'b00);
    chk("rst_s0_cyc", s0_cyc, 0);
    chk("rst_s0_stb", s0_stb, 0);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
`ifdef CELLRAM_SCHED_STATS_EN
    chk("rst_stats", {st_m0, st_m1, st_to}, 40'd0);
`endif
    step();
    rst_n = 1'b1;

    // m0-only read
    step();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    smp();
    chk("t1_arb_latency_cyc", s0_cyc, 0);
    chk("t1_arb_latency_sel", mst_sel, 2'b00);
    step(); smp();
    chk("t1_grant_sel", mst_sel, 2'b01);
    chk("t1_s0_cyc", s0_cyc, 1);
    chk("t1_s0_adr", s0_adr, 32'h100);
    step();
    step();
    s0_ack = 1; s0_rdat = 32'hCAFE0001;
    smp();
    chk("t1_m0_ack", m0_ack, 1);
    chk("t1_m0_dat", m0_rdat, 32'hCAFE0001);
    chk("t1_m1_ack", m1_ack, 0);
    chk("t1_m1_dat", m1_rdat, 32'h0);
    step();
    s0_ack = 0; m0_cyc = 0; m0_stb = 0;
    smp();
    chk("t1_last_grant_cycle", mst_sel, 2'b01);
    step(); smp();
    chk("t1_idle", mst_sel, 2'b00);

    // both masters request continuously, one beat per grant
    step();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    prev_sel = 2'b00;
    acked = 0;
    for (int c = 0; c < 200 && grants.size() < 10; c++) begin
      step();
      if (mst_sel != 2'b00 && prev_sel == 2'b00) grants.push_back(int'(mst_sel));
      if (mst_sel != 2'b00 && !acked) begin
        s0_ack = 1; acked = 1;
      end else if (mst_sel != 2'b00) begin
        s0_ack = 0;
        if (mst_sel == 2'b01) begin m0_cyc = 0; m0_stb = 0; end
        else begin m1_cyc = 0; m1_stb = 0; end
      end else begin
        acked = 0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      end
      prev_sel = mst_sel;
    end
    chk("t2_grant_count", grants.size(), 10);
    for (int i = 0; i < grants.size() && i < 10; i++) chk($sformatf("t2_grant_%0d", i), grants[i], exp_g[i]);
    run = 0; max_run = 0;
    foreach (grants[i]) begin
      if (grants[i] == 1) run++; else run = 0;
      if (run > max_run) max_run = run;
    end
    chk("t2_max_m0_run_le4", (max_run <= 4), 1);
    step();
    s0_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    repeat (3) step();

    // m0 8-beat locked burst while m1 waits
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h200;
    smp();
    step(); smp();
    chk("t3_grant_m0", mst_sel, 2'b01);
    for (int b = 0; b < 8; b++) begin
      step();
      s0_ack = 1; s0_rdat = 32'h1000 + b;
      smp();
      chk($sformatf("t3_m0_ack_%0d", b), m0_ack, 1);
      chk($sformatf("t3_m0_dat_%0d", b), m0_rdat, 32'h1000 + b);
      chk($sformatf("t3_m1_ack_%0d", b), m1_ack, 0);
    end
    step();
    s0_ack = 0; m0_cyc = 0; m0_stb = 0;
    smp();
    chk("t3_hold_m0", mst_sel, 2'b01);
    step(); smp();
    chk("t3_bubble", mst_sel, 2'b00);
    step(); smp();
    chk("t3_grant_m1", mst_sel, 2'b10);
    chk("t3_s0_we", s0_we, 1);
    chk("t3_s0_adr", s0_adr, 32'h200);

    // slave never acks the m1 write (that grant cycle is strobe cycle 1)
    early = 0;
    for (int k = 2; k <= 63; k++) begin
      step(); smp();
      if (m1_err) early++;
    end
    chk("t4_no_early_err", early, 0);
    step(); smp();
    chk("t4_err_at_64", m1_err, 1);
    chk("t4_cyc_at_64", s0_cyc, 1);
    chk("t4_m0_err", m0_err, 0);
    step();
    s0_ack = 1;
    smp();
    chk("t4_drain_cyc", s0_cyc, 0);
    chk("t4_drain_stb", s0_stb, 0);
    chk("t4_err_one_pulse", m1_err, 0);
    chk("t4_late_ack_dropped", m1_ack, 0);
    chk("t4_drain_sel", mst_sel, 2'b00);
    step();
    s0_ack = 0; m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h300;
    smp();
    chk("t4_drain_hold", s0_cyc, 0);
    step(); smp();
    chk("t4_drain_hold_sel", mst_sel, 2'b00);
    step();
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    smp();
    step(); smp();
    chk("t4_idle_after_drain", mst_sel, 2'b00);
    step(); smp();
    chk("t4_m0_serviced", mst_sel, 2'b01);
    chk("t4_m0_adr", s0_adr, 32'h300);

    // ack arriving in the same cycle as the timeout
    step();
    s0_ack = 1; s0_rdat = 32'h55;
    smp();
    chk("t5_first_ack", m0_ack, 1);
    step();
    s0_ack = 0;
    smp();
    early = 0;
    for (int k = 2; k <= 63; k++) begin
      step(); smp();
      if (m0_err) early++;
    end
    chk("t5_no_early_err", early, 0);
    step();
    s0_ack = 1; s0_rdat = 32'hABCD;
    smp();
    chk("t5_ack_wins", m0_ack, 1);
    chk("t5_no_err", m0_err, 0);
    chk("t5_dat", m0_rdat, 32'hABCD);
    step();
    s0_ack = 0;
    smp();
    chk("t5_still_granted", mst_sel, 2'b01);
    chk("t5_s0_cyc", s0_cyc, 1);
`ifdef CELLRAM_SCHED_STATS_EN
    chk("t5_stat_timeouts", st_to, 8'd1);
    chk("t5_stat_m0", st_m0, 16'd11);
    chk("t5_stat_m1", st_m1, 16'd3);
`endif

    // reset in the middle of an m1 transfer
    step();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1; m1_we = 1;
    smp();
    step(); smp();
    chk("t6_idle", mst_sel, 2'b00);
    step(); smp();
    chk("t6_grant_m1", mst_sel, 2'b10);
    step(); smp();
    chk("t6_mid_cyc", s0_cyc, 1);
    step();
    rst_n = 1'b0;
    smp();
    step(); smp();
    chk("t6_rst_cyc", s0_cyc, 0);
    chk("t6_rst_stb", s0_stb, 0);
    chk("t6_rst_sel", mst_sel, 2'b00);
`ifdef CELLRAM_SCHED_STATS_EN
    chk("t6_rst_stats", {st_m0, st_m1, st_to}, 40'd0);
`endif
    step();
    rst_n = 1'b1; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
